capture_sequencer: RTL and testbench

CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

---
 rtl/capture_sequencer_if.sv | 34 +++
 rtl/capture_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_capture_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/capture_sequencer_if.sv
// Wishbone slave bundle for the capture sequencer register block.
// Master drives strobes/address/data, slave returns ack and read data.
interface capture_sequencer_if;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [1:0]  wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack;

  modport master (
    output wb_cyc,
    output wb_stb,
    output wb_we,
    output wb_adr,
    output wb_sel,
    output wb_dat_i,
    input  wb_dat_o,
    input  wb_ack
  );

  modport slave (
    input  wb_cyc,
    input  wb_stb,
    input  wb_we,
    input  wb_adr,
    input  wb_sel,
    input  wb_dat_i,
    output wb_dat_o,
    output wb_ack
  );
endinterface

// File: rtl/capture_sequencer.sv
// Capture sequencer: arms an external capture buffer, waits for it to fill,
// counts completed captures and raises a level interrupt on done/timeout.
module capture_sequencer #(
  parameter int TMO_WIDTH = 24,
  parameter int CNT_WIDTH = 16
) (
  input  logic               wb_clk,
  input  logic               wb_rst_n,
  capture_sequencer_if.slave bus,
  output logic               cntrl_run,
  input  logic               cntrl_ready,
  output logic               busy,
  output logic               irq
);

  localparam logic [31:0] ID_VAL = 32'h5EC0_0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic run_q, run_d;
  logic ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic sync_q, rdy_s_q;
  logic auto_q, auto_d;
  logic irq_en_q, irq_en_d;
  logic done_q, done_d;
  logic tmo_q, tmo_d;
  logic irq_q, irq_d;

  logic [TMO_WIDTH-1:0] lim_q, lim_d;
  logic [TMO_WIDTH-1:0] tcnt_q, tcnt_d;
  logic [TMO_WIDTH-1:0] tcnt_inc;
  logic [CNT_WIDTH-1:0] cap_q, cap_d;

  logic acc, wr;
  logic wr_csr, wr_lim, wr_cap;
  logic start_w, abort_w;
  logic done_clr, tmo_clr;
  logic done_set, tmo_set;
  logic tmo_hit;
  logic [31:0] mask;
  logic [31:0] csr_rd;
  logic unused_ok;

  assign acc    = bus.wb_cyc & bus.wb_stb & ~ack_q;
  assign wr     = acc & bus.wb_we;
  assign wr_csr = wr & (bus.wb_adr == 2'd0);
  assign wr_lim = wr & (bus.wb_adr == 2'd1);
  assign wr_cap = wr & (bus.wb_adr == 2'd2);

  assign start_w  = wr_csr & bus.wb_sel[0]
                  & bus.wb_dat_i[0];
  assign abort_w  = wr_csr & bus.wb_sel[0]
                  & bus.wb_dat_i[3];
  assign done_clr = wr_csr & bus.wb_sel[1]
                  & bus.wb_dat_i[8];
  assign tmo_clr  = wr_csr & bus.wb_sel[1]
                  & bus.wb_dat_i[9];

  assign mask = {{8{bus.wb_sel[3]}},
                 {8{bus.wb_sel[2]}},
                 {8{bus.wb_sel[1]}},
                 {8{bus.wb_sel[0]}}};

  // The flag lands on the same edge the counter reaches the limit.
  assign tcnt_inc = tcnt_q + 1'b1;
  assign tmo_hit  = (lim_q != '0) && (tcnt_inc == lim_q);

  assign unused_ok = ^{bus.wb_dat_i, mask};

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    done_set = 1'b0;
    tmo_set  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_w) begin
          state_d = ARM;
          tcnt_d  = '0;
        end
      end
      ARM: begin
        tcnt_d = tcnt_inc;
        if (tmo_hit) begin
          state_d = IDLE;
          tmo_set = 1'b1;
        end else if (!rdy_s_q) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        tcnt_d = tcnt_inc;
        if (rdy_s_q) begin
          state_d = DONE;
        end else if (tmo_hit) begin
          state_d = IDLE;
          tmo_set = 1'b1;
        end
      end
      DONE: begin
        done_set = 1'b1;
        if (auto_q) begin
          state_d = ARM;
          tcnt_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort leaves flags and the capture count exactly as they were.
    if (abort_w) begin
      state_d  = IDLE;
      done_set = 1'b0;
      tmo_set  = 1'b0;
    end
  end

  always_comb begin
    run_d    = (state_d == ARM);
    ack_d    = acc;
    auto_d   = auto_q;
    irq_en_d = irq_en_q;
    if (wr_csr && bus.wb_sel[0]) begin
      auto_d   = bus.wb_dat_i[1];
      irq_en_d = bus.wb_dat_i[2];
    end
    done_d = done_set | (done_q & ~done_clr);
    tmo_d  = tmo_set | (tmo_q & ~tmo_clr);
    irq_d  = irq_en_q & (done_q | tmo_q);
  end

  always_comb begin
    lim_d = lim_q;
    if (wr_lim) begin
      lim_d = (lim_q & ~mask[TMO_WIDTH-1:0])
            | (bus.wb_dat_i[TMO_WIDTH-1:0]
               & mask[TMO_WIDTH-1:0]);
    end
    cap_d = cap_q;
    if (wr_cap) begin
      cap_d = '0;
    end else if (done_set && (cap_q != '1)) begin
      cap_d = cap_q + 1'b1;
    end
  end

  always_comb begin
    csr_rd = {21'b0, rdy_s_q, tmo_q, done_q,
              2'b00, 2'(state_q), 1'b0,
              irq_en_q, auto_q, 1'b0};
    dat_d  = dat_q;
    if (acc) begin
      unique case (bus.wb_adr)
        2'd0: dat_d = csr_rd;
        2'd1: dat_d = 32'(lim_q);
        2'd2: dat_d = 32'(cap_q);
        2'd3: dat_d = ID_VAL;
        default: dat_d = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q  <= IDLE;
      run_q    <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      sync_q   <= 1'b0;
      rdy_s_q  <= 1'b0;
      auto_q   <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
      irq_q    <= 1'b0;
      lim_q    <= '0;
      tcnt_q   <= '0;
      cap_q    <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      sync_q   <= cntrl_ready;
      rdy_s_q  <= sync_q;
      auto_q   <= auto_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      irq_q    <= irq_d;
      lim_q    <= lim_d;
      tcnt_q   <= tcnt_d;
      cap_q    <= cap_d;
    end
  end

  assign cntrl_run    = run_q;
  assign busy         = (state_q != IDLE);
  assign irq          = irq_q;
  assign bus.wb_ack   = ack_q;
  assign bus.wb_dat_o = dat_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: buffer model, bus tasks and a register
// model that predicts readback from the documented register rules.
module tb_capture_sequencer;

  localparam logic [31:0] ID_VAL = 32'h5EC0_0001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cntrl_run;
  logic cntrl_ready;
  logic busy;
  logic irq;

  capture_sequencer_if bif();

  capture_sequencer #(
    .TMO_WIDTH(24),
    .CNT_WIDTH(16)
  ) dut (
    .wb_clk     (clk),
    .wb_rst_n   (rst_n),
    .bus        (bif.slave),
    .cntrl_run  (cntrl_run),
    .cntrl_ready(cntrl_ready),
    .busy       (busy),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int buf_mode = 0;
  int drop_dly = 3;
  int fill_dly = 40;
  int buf_caps = 0;
  logic ready_lvl = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h",
               tag, got, exp);
    end
  endtask

  // Buffer model: mode 0 follows ready_lvl, mode 1 runs a fill cycle
  // each time it sees run while full.
  initial begin
    cntrl_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (buf_mode != 0) begin
        if (cntrl_run && cntrl_ready) begin
          repeat (drop_dly) @(posedge clk);
          #1;
          if (buf_mode != 0) cntrl_ready = 1'b0;
          repeat (fill_dly) @(posedge clk);
          #1;
          if (buf_mode != 0) begin
            cntrl_ready = 1'b1;
            buf_caps++;
          end
        end
      end else begin
        cntrl_ready = ready_lvl;
      end
    end
  end

  task automatic bus(input logic [1:0] a,
                     input logic we,
                     input logic [31:0] d,
                     input logic [3:0] s,
                     output logic [31:0] q);
    int n;
    @(posedge clk);
    #1;
    bif.wb_adr   = a;
    bif.wb_we    = we;
    bif.wb_dat_i = d;
    bif.wb_sel   = s;
    bif.wb_cyc   = 1'b1;
    bif.wb_stb   = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bif.wb_ack && n < 8);
    check("ack", {31'b0, bif.wb_ack}, 32'd1);
    q = bif.wb_dat_o;
    bif.wb_cyc = 1'b0;
    bif.wb_stb = 1'b0;
    bif.wb_we  = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [31:0] d,
                    input logic [3:0] s);
    logic [31:0] q;
    bus(a, 1'b1, d, s, q);
  endtask

  task automatic rd(input logic [1:0] a,
                    output logic [31:0] q);
    bus(a, 1'b0, 32'h0, 4'hF, q);
  endtask

  initial begin
    logic [31:0] q;
    logic [31:0] d;
    logic [3:0]  s;
    logic [23:0] lim_m;
    logic        auto_m, ien_m, done_m;
    int n, runc, busyc, caps0;

    bif.wb_cyc   = 1'b0;
    bif.wb_stb   = 1'b0;
    bif.wb_we    = 1'b0;
    bif.wb_adr   = 2'd0;
    bif.wb_sel   = 4'h0;
    bif.wb_dat_i = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_run", {31'b0, cntrl_run}, 0);
    check("rst_ack", {31'b0, bif.wb_ack}, 0);
    check("rst_irq", {31'b0, irq}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(2'd0, q); check("rst_csr", q, 0);
    rd(2'd1, q); check("rst_lim", q, 0);
    rd(2'd2, q); check("rst_cap", q, 0);
    rd(2'd3, q); check("rst_id", q, ID_VAL);

    // Single capture with interrupt enabled.
    ready_lvl = 1'b1;
    repeat (4) @(posedge clk);
    drop_dly = 3;
    fill_dly = 40;
    buf_mode = 1;
    caps0 = buf_caps;
    wr(2'd0, 32'h5, 4'hF);
    check("c1_run_start", {31'b0, cntrl_run}, 1);
    runc = 0;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      if (cntrl_run) runc++;
      n++;
    end
    check("c1_finish", {31'b0, busy}, 0);
    check("c1_run_hold",
          {31'b0, (runc >= drop_dly + 2)
                  && (runc <= drop_dly + 4)}, 1);
    rd(2'd0, q); check("c1_csr", q, 32'h504);
    check("c1_irq", {31'b0, irq}, 1);
    check("c1_run_end", {31'b0, cntrl_run}, 0);
    rd(2'd2, q); check("c1_cap", q, 1);
    check("c1_bufcaps", buf_caps - caps0, 1);

    // W1C of DONE together with ABORT, then START with ABORT.
    wr(2'd0, 32'h108, 4'h3);
    repeat (2) @(posedge clk);
    #1;
    check("w1c_irq", {31'b0, irq}, 0);
    rd(2'd0, q); check("w1c_csr", q, 32'h400);
    wr(2'd0, 32'h9, 4'h3);
    runc = 0;
    busyc = 0;
    repeat (12) begin
      @(negedge clk);
      if (cntrl_run) runc++;
      if (busy) busyc++;
    end
    check("sa_run", runc, 0);
    check("sa_busy", busyc, 0);
    rd(2'd0, q); check("sa_csr", q, 32'h400);

    // Timeout with the buffer never filling.
    buf_mode = 0;
    ready_lvl = 1'b0;
    repeat (4) @(posedge clk);
    wr(2'd2, 32'h0, 4'hF);
    rd(2'd2, q); check("t_capclr", q, 0);
    wr(2'd1, 32'd100, 4'hF);
    wr(2'd0, 32'h1, 4'h1);
    check("t_busy", {31'b0, busy}, 1);
    n = 0;
    while (busy && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t_cycles", n, 100);
    check("t_run", {31'b0, cntrl_run}, 0);
    rd(2'd0, q); check("t_csr", q, 32'h200);
    rd(2'd2, q); check("t_cap", q, 0);
    wr(2'd0, 32'h200, 4'h2);
    wr(2'd1, 32'h0, 4'hF);
    rd(2'd0, q); check("t_clr", q, 0);

    // Auto re-arm with random buffer timing, then abort.
    ready_lvl = 1'b1;
    repeat (4) @(posedge clk);
    drop_dly = $urandom_range(2, 6);
    fill_dly = $urandom_range(14, 30);
    buf_mode = 1;
    caps0 = buf_caps;
    wr(2'd0, 32'h3, 4'h1);
    n = 0;
    while ((buf_caps - caps0) < 3 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("a_three", buf_caps - caps0, 3);
    repeat (8) @(posedge clk);
    wr(2'd0, 32'h8, 4'h1);
    @(posedge clk);
    #1;
    check("a_run", {31'b0, cntrl_run}, 0);
    check("a_busy", {31'b0, busy}, 0);
    rd(2'd2, q); check("a_cap", q, 3);
    rd(2'd0, q); check("a_csr", q & 32'h336, 32'h100);
    buf_mode = 0;
    repeat (60) @(posedge clk);

    // Back-to-back reads with cyc/stb held.
    @(posedge clk);
    #1;
    bif.wb_adr = 2'd3;
    bif.wb_we  = 1'b0;
    bif.wb_sel = 4'hF;
    bif.wb_cyc = 1'b1;
    bif.wb_stb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("b2b_ack", {31'b0, bif.wb_ack},
            (i % 2 == 0) ? 32'd1 : 32'd0);
      if (bif.wb_ack) check("b2b_dat", bif.wb_dat_o, ID_VAL);
    end
    bif.wb_cyc = 1'b0;
    bif.wb_stb = 1'b0;
    wr(2'd2, 32'hFFFF, 4'hF);
    rd(2'd2, q); check("cap_wclr", q, 0);

    // Random register traffic against the register model.
    lim_m  = 24'h0;
    auto_m = 1'b0;
    ien_m  = 1'b0;
    done_m = 1'b1;
    for (int i = 0; i < 12; i++) begin
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      wr(2'd1, d, s);
      for (int b = 0; b < 3; b++) begin
        if (s[b]) lim_m[8*b +: 8] = d[8*b +: 8];
      end
      rd(2'd1, q); check("rnd_lim", q, {8'h0, lim_m});
      d = $urandom & 32'h0000_0306;
      s = 4'($urandom_range(0, 15));
      wr(2'd0, d, s);
      if (s[0]) begin
        auto_m = d[1];
        ien_m  = d[2];
      end
      if (s[1] && d[8]) done_m = 1'b0;
      rd(2'd0, q);
      check("rnd_csr", q,
            {21'b0, 1'b1, 1'b0, done_m, 5'b0,
             ien_m, auto_m, 1'b0});
      check("rnd_irq", {31'b0, irq},
            {31'b0, ien_m & done_m});
    end
    wr(2'd1, 32'h0, 4'hF);

    // Reset while waiting for the buffer to fill.
    drop_dly = 3;
    fill_dly = 40;
    buf_mode = 1;
    wr(2'd0, 32'h5, 4'hF);
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("r_first", {31'b0, busy}, 0);
    wr(2'd0, 32'h5, 4'hF);
    repeat (12) @(negedge clk);
    check("r_wait_busy", {31'b0, busy}, 1);
    check("r_wait_run", {31'b0, cntrl_run}, 0);
    check("r_wait_irq", {31'b0, irq}, 1);
    rd(2'd0, q); check("r_wait_st", q & 32'h30, 32'h20);
    @(negedge clk);
    rst_n = 1'b0;
    buf_mode = 0;
    ready_lvl = 1'b0;
    #1;
    check("r_run", {31'b0, cntrl_run}, 0);
    check("r_busy", {31'b0, busy}, 0);
    check("r_irq", {31'b0, irq}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    rd(2'd0, q); check("r_csr", q, 0);
    rd(2'd1, q); check("r_lim", q, 0);
    rd(2'd2, q); check("r_cap", q, 0);
    rd(2'd3, q); check("r_id", q, ID_VAL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
